he_lb_csr_responder: RTL

Device-side MMIO responder for the host-exerciser loopback (HE-LB) CSR space. Accepts host read/write requests on a valid/ready request channel, decodes the fixed HE-LB address map, holds the engine configuration registers, and returns one tagged read completion per read. It sits between the AFU MMIO shim and the HE-LB traffic engine, driving engine controls and reflecting engine status.

---
 rtl/he_lb_csr_pkg.sv | 85 ++++++++
 rtl/he_lb_csr_rd_mux.sv | 80 ++++++++
 rtl/he_lb_csr_responder.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/he_lb_csr_pkg.sv
// rtl/he_lb_csr_pkg.sv - shared HE-LB CSR address map, INFO0 layout and decode helpers
package he_lb_csr_pkg;

    // Byte addresses of the HE-LB CSR space
    localparam logic [15:0] ADDR_DFH          = 16'h000;
    localparam logic [15:0] ADDR_ID_L         = 16'h008;
    localparam logic [15:0] ADDR_ID_H         = 16'h010;
    localparam logic [15:0] ADDR_SCRATCHPAD0  = 16'h100;
    localparam logic [15:0] ADDR_SCRATCHPAD1  = 16'h104;
    localparam logic [15:0] ADDR_SCRATCHPAD2  = 16'h108;
    localparam logic [15:0] ADDR_DSM_BASEL    = 16'h110;
    localparam logic [15:0] ADDR_DSM_BASEH    = 16'h114;
    localparam logic [15:0] ADDR_SRC_ADDR     = 16'h120;
    localparam logic [15:0] ADDR_DST_ADDR     = 16'h128;
    localparam logic [15:0] ADDR_NUM_LINES    = 16'h130;
    localparam logic [15:0] ADDR_CTL          = 16'h138;
    localparam logic [15:0] ADDR_CFG          = 16'h140;
    localparam logic [15:0] ADDR_INACT_THRESH = 16'h148;
    localparam logic [15:0] ADDR_INTERRUPT0   = 16'h150;
    localparam logic [15:0] ADDR_SWTEST_MSG   = 16'h158;
    localparam logic [15:0] ADDR_STATUS0      = 16'h160;
    localparam logic [15:0] ADDR_STATUS1      = 16'h168;
    localparam logic [15:0] ADDR_ERROR        = 16'h170;
    localparam logic [15:0] ADDR_STRIDE       = 16'h178;
    localparam logic [15:0] ADDR_INFO0        = 16'h180;

    typedef struct packed {
        logic [4:0]  local_mem_width_shift;
        logic [1:0]  bus_width_shift;
        logic        atomics_supported;
        logic [7:0]  api_version;
        logic [15:0] clk_mhz;
    } t_info0;

    // One entry per qword of the map; 32-bit registers sharing a qword
    // (SP0/SP1, DSM_BASEL/H) are handled as a single 64-bit entry.
    typedef enum logic [4:0] {
        R_NONE, R_DFH, R_ID_L, R_ID_H, R_SP01, R_SP2, R_DSM, R_SRC, R_DST,
        R_NUM, R_CTL, R_CFG, R_INACT, R_INT0, R_SWTEST, R_STAT0, R_STAT1,
        R_ERR, R_STRIDE, R_INFO0
    } t_csr_reg;

    typedef enum logic {S_IDLE, S_RSP} t_rsp_state;

    function automatic t_csr_reg decode_qword(input logic [12:0] qa);
        t_csr_reg r;
        r = R_NONE;
        case (qa)
            ADDR_DFH[15:3]:          r = R_DFH;
            ADDR_ID_L[15:3]:         r = R_ID_L;
            ADDR_ID_H[15:3]:         r = R_ID_H;
            ADDR_SCRATCHPAD0[15:3]:  r = R_SP01;
            ADDR_SCRATCHPAD2[15:3]:  r = R_SP2;
            ADDR_DSM_BASEL[15:3]:    r = R_DSM;
            ADDR_SRC_ADDR[15:3]:     r = R_SRC;
            ADDR_DST_ADDR[15:3]:     r = R_DST;
            ADDR_NUM_LINES[15:3]:    r = R_NUM;
            ADDR_CTL[15:3]:          r = R_CTL;
            ADDR_CFG[15:3]:          r = R_CFG;
            ADDR_INACT_THRESH[15:3]: r = R_INACT;
            ADDR_INTERRUPT0[15:3]:   r = R_INT0;
            ADDR_SWTEST_MSG[15:3]:   r = R_SWTEST;
            ADDR_STATUS0[15:3]:      r = R_STAT0;
            ADDR_STATUS1[15:3]:      r = R_STAT1;
            ADDR_ERROR[15:3]:        r = R_ERR;
            ADDR_STRIDE[15:3]:       r = R_STRIDE;
            ADDR_INFO0[15:3]:        r = R_INFO0;
            default:                 r = R_NONE;
        endcase
        return r;
    endfunction

    // Update only the dword lanes enabled by the access
    function automatic logic [63:0] merge_lanes(input logic [63:0] old_val,
                                                input logic [63:0] wd,
                                                input logic        lo,
                                                input logic        hi);
        logic [63:0] v;
        v = old_val;
        if (lo) v[31:0]  = wd[31:0];
        if (hi) v[63:32] = wd[63:32];
        return v;
    endfunction

endpackage

// File: rtl/he_lb_csr_rd_mux.sv
// rtl/he_lb_csr_rd_mux.sv - HE-LB CSR address decode, lane enables and read-data select
//
// Ports:
//   addr[15:2], len8      access address (dword granular) and size
//   sel                   decoded register (R_NONE for unmapped or misaligned 8B)
//   lane_lo, lane_hi      dword lanes touched by the access
//   rdata                 read data, 4B reads replicated into both dwords
//   sp01..stride          current register / status values
module he_lb_csr_rd_mux
    import he_lb_csr_pkg::*;
#(
    parameter logic [63:0] DFH_VALUE = 64'h1000_0000_0000_0001,
    parameter logic [63:0] AFU_ID_L  = 64'h0,
    parameter logic [63:0] AFU_ID_H  = 64'h0,
    parameter logic [31:0] INFO0     = 32'h0
) (
    input  logic [15:2] addr,
    input  logic        len8,
    output t_csr_reg    sel,
    output logic        lane_lo,
    output logic        lane_hi,
    output logic [63:0] rdata,
    input  logic [63:0] sp01,
    input  logic [31:0] sp2,
    input  logic [63:0] dsm,
    input  logic [63:0] src,
    input  logic [63:0] dst,
    input  logic [31:0] num_lines,
    input  logic        ctl_rst,
    input  logic [63:0] cfg,
    input  logic [63:0] inact,
    input  logic [63:0] int0,
    input  logic [63:0] swtest,
    input  logic [63:0] status0,
    input  logic [63:0] status1,
    input  logic [63:0] error,
    input  logic [63:0] stride
);

    logic [63:0] qv;

    always_comb begin
        // An 8-byte access to the upper dword is treated as unmapped
        sel     = (len8 && addr[2]) ? R_NONE : decode_qword(addr[15:3]);
        lane_lo = len8 || !addr[2];
        lane_hi = len8 || addr[2];

        qv = 64'h0;
        case (sel)
            R_DFH:    qv = DFH_VALUE;
            R_ID_L:   qv = AFU_ID_L;
            R_ID_H:   qv = AFU_ID_H;
            R_SP01:   qv = sp01;
            R_SP2:    qv = {32'h0, sp2};
            R_DSM:    qv = dsm;
            R_SRC:    qv = src;
            R_DST:    qv = dst;
            R_NUM:    qv = {32'h0, num_lines};
            R_CTL:    qv = {63'h0, ctl_rst};
            R_CFG:    qv = cfg;
            R_INACT:  qv = inact;
            R_INT0:   qv = int0;
            R_SWTEST: qv = swtest;
            R_STAT0:  qv = status0;
            R_STAT1:  qv = status1;
            R_ERR:    qv = error;
            R_STRIDE: qv = stride;
            R_INFO0:  qv = {32'h0, INFO0};
            default:  qv = 64'h0;
        endcase

        if (len8)
            rdata = qv;
        else if (addr[2])
            rdata = {qv[63:32], qv[63:32]};
        else
            rdata = {qv[31:0], qv[31:0]};
    end

endmodule

// File: rtl/he_lb_csr_responder.sv
// rtl/he_lb_csr_responder.sv - HE-LB MMIO CSR responder: register file, engine controls, tagged read completions
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_*                           MMIO request channel (valid/ready)
//   rsp_*                           read completion channel (valid/ready)
//   eng_rst_n, eng_start, eng_stop  engine soft reset level and control pulses
//   dsm_base..num_lines             engine configuration registers
//   status0, status1, error         engine status inputs (read-only CSRs)
module he_lb_csr_responder
    import he_lb_csr_pkg::*;
#(
    parameter logic [63:0] DFH_VALUE             = 64'h1000_0000_0000_0001,
    parameter logic [63:0] AFU_ID_L              = 64'h0,
    parameter logic [63:0] AFU_ID_H              = 64'h0,
    parameter logic [15:0] CLK_MHZ               = 16'd0,
    parameter logic [7:0]  API_VERSION           = 8'd2,
    parameter logic        ATOMICS_SUPPORTED     = 1'b0,
    parameter logic [1:0]  BUS_WIDTH_SHIFT       = 2'd1,
    parameter logic [4:0]  LOCAL_MEM_WIDTH_SHIFT = 5'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic        req_len8,
    input  logic [63:0] req_wdata,
    input  logic [9:0]  req_tag,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [9:0]  rsp_tag,
    output logic [63:0] rsp_data,
    output logic        eng_rst_n,
    output logic        eng_start,
    output logic        eng_stop,
    output logic [63:0] dsm_base,
    output logic [63:0] src_addr,
    output logic [63:0] dst_addr,
    output logic [63:0] cfg,
    output logic [63:0] inact_thresh,
    output logic [63:0] interrupt0,
    output logic [63:0] swtest_msg,
    output logic [63:0] stride,
    output logic [31:0] num_lines,
    input  logic [63:0] status0,
    input  logic [63:0] status1,
    input  logic [63:0] error
);

    localparam t_info0 INFO0_VAL = '{
        local_mem_width_shift: LOCAL_MEM_WIDTH_SHIFT,
        bus_width_shift:       BUS_WIDTH_SHIFT,
        atomics_supported:     ATOMICS_SUPPORTED,
        api_version:           API_VERSION,
        clk_mhz:               CLK_MHZ
    };

    t_rsp_state  state, state_next;
    t_csr_reg    sel;
    logic        lane_lo, lane_hi;
    logic [63:0] rdata;
    logic [63:0] wd;
    logic [63:0] sp01;
    logic [31:0] sp2;
    logic        accept, wr_en, rd_capture;
    logic        ctl_wr, ctl_rst_new;

    // Byte offset within a dword carries no meaning in this map
    logic        unused_addr_lsb;
    assign unused_addr_lsb = &{1'b0, req_addr[1:0]};

    he_lb_csr_rd_mux #(
        .DFH_VALUE (DFH_VALUE),
        .AFU_ID_L  (AFU_ID_L),
        .AFU_ID_H  (AFU_ID_H),
        .INFO0     (INFO0_VAL)
    ) u_rd_mux (
        .addr      (req_addr[15:2]),
        .len8      (req_len8),
        .sel       (sel),
        .lane_lo   (lane_lo),
        .lane_hi   (lane_hi),
        .rdata     (rdata),
        .sp01      (sp01),
        .sp2       (sp2),
        .dsm       (dsm_base),
        .src       (src_addr),
        .dst       (dst_addr),
        .num_lines (num_lines),
        .ctl_rst   (eng_rst_n),
        .cfg       (cfg),
        .inact     (inact_thresh),
        .int0      (interrupt0),
        .swtest    (swtest_msg),
        .status0   (status0),
        .status1   (status1),
        .error     (error),
        .stride    (stride)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        rd_capture = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                accept    = req_valid;
                if (req_valid && !req_write) begin
                    rd_capture = 1'b1;
                    state_next = S_RSP;
                end
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Align write data to lanes: a 4B write carries its dword in [31:0]
    assign wd          = req_len8 ? req_wdata : {req_wdata[31:0], req_wdata[31:0]};
    assign wr_en       = accept && req_write;
    assign ctl_wr      = wr_en && (sel == R_CTL) && lane_lo;
    assign ctl_rst_new = wd[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= 64'h0;
            rsp_tag  <= 10'h0;
        end else if (rd_capture) begin
            rsp_data <= rdata;
            rsp_tag  <= req_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp01         <= 64'h0;
            sp2          <= 32'h0;
            dsm_base     <= 64'h0;
            src_addr     <= 64'h0;
            dst_addr     <= 64'h0;
            num_lines    <= 32'h0;
            cfg          <= 64'h0;
            inact_thresh <= 64'h0;
            interrupt0   <= 64'h0;
            swtest_msg   <= 64'h0;
            stride       <= 64'h0;
            eng_rst_n    <= 1'b0;
            eng_start    <= 1'b0;
            eng_stop     <= 1'b0;
        end else begin
            eng_start <= 1'b0;
            eng_stop  <= 1'b0;
            if (wr_en) begin
                case (sel)
                    R_SP01:   sp01         <= merge_lanes(sp01, wd, lane_lo, lane_hi);
                    R_SP2:    if (lane_lo) sp2 <= wd[31:0];
                    R_DSM:    dsm_base     <= merge_lanes(dsm_base, wd, lane_lo, lane_hi);
                    R_SRC:    src_addr     <= merge_lanes(src_addr, wd, lane_lo, lane_hi);
                    R_DST:    dst_addr     <= merge_lanes(dst_addr, wd, lane_lo, lane_hi);
                    R_NUM:    if (lane_lo) num_lines <= wd[31:0];
                    R_CFG:    cfg          <= merge_lanes(cfg, wd, lane_lo, lane_hi);
                    R_INACT:  inact_thresh <= merge_lanes(inact_thresh, wd, lane_lo, lane_hi);
                    R_INT0:   interrupt0   <= merge_lanes(interrupt0, wd, lane_lo, lane_hi);
                    R_SWTEST: swtest_msg   <= merge_lanes(swtest_msg, wd, lane_lo, lane_hi);
                    R_STRIDE: stride       <= merge_lanes(stride, wd, lane_lo, lane_hi);
                    default: ;
                endcase
            end
            if (ctl_wr) begin
                eng_rst_n <= ctl_rst_new;
                eng_stop  <= wd[2];
                // Stop wins over start; start is meaningless while the engine is held in reset
                eng_start <= wd[1] && !wd[2] && ctl_rst_new;
            end
        end
    end

endmodule
